// File: rtl/matrix_result_streamer_pkg.sv
// Shared definitions for the result read-out / transmit path.
// Holds matrix geometry, the matrix_select code of the result matrix,
// the frame header byte (also used by the UART and matrix_controller),
// and the streamer FSM state encoding.
package matrix_result_streamer_pkg;

  localparam int unsigned DIM    = 10;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;

  localparam logic [1:0]        RESULT_SEL = 2'd2;
  localparam logic [DATA_W-1:0] HEADER     = 8'hA5;

  typedef enum logic [3:0] {
    IDLE,
    HDR,
    RD_ADDR,
    RD_WAIT,
    LOAD,
    WAIT_ACK,
    WAIT_DONE,
    CSUM,
    FIN
  } streamer_state_t;

  // Which kind of byte is currently in flight; selects the step after WAIT_DONE.
  typedef enum logic [1:0] {
    SENT_HDR,
    SENT_DATA,
    SENT_CSUM
  } sent_kind_t;

endpackage

// File: rtl/matrix_result_streamer_sync_2ff.sv
// Generic 1-bit two-flop synchroniser.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears both flops
//   d     - asynchronous input
//   q     - synchronised output
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/matrix_result_streamer.sv
// Reads the DIM x DIM result matrix row-major from the shared memory bank
// and streams it to the UART Transmitter as: header, DIM*DIM data bytes,
// XOR checksum of the data bytes.
// Ports:
//   clk            - system clock
//   reset          - asynchronous active-low reset
//   start          - one-cycle pulse, begins a frame when idle
//   mem_read_data  - memory read data, valid 1 clk after address
//   tx_busy        - Transmitter busy (bclk domain)
//   mem_matrix_sel - RESULT_SEL while busy, else 0
//   mem_row/col    - read address
//   mem_write_en   - always 0
//   tx_load        - load request to Transmitter
//   tx_data        - byte to send, stable while tx_load is high
//   busy           - frame in progress
//   done           - one-cycle pulse after the checksum byte is sent
//   error          - sticky ack-timeout flag, cleared by next accepted start
module matrix_result_streamer
  import matrix_result_streamer_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              tx_busy,
  output logic [1:0]        mem_matrix_sel,
  output logic [ADDR_W-1:0] mem_row,
  output logic [ADDR_W-1:0] mem_col,
  output logic              mem_write_en,
  output logic              tx_load,
  output logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned        TIMER_W   = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(ACK_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0]  LAST      = ADDR_W'(DIM - 1);

  streamer_state_t     state;
  sent_kind_t          sent;
  logic [ADDR_W-1:0]   row;
  logic [ADDR_W-1:0]   col;
  logic [DATA_W-1:0]   csum;
  logic [TIMER_W-1:0]  timer;
  logic                armed;
  logic                tb_s;

  sync_2ff u_busy_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (tx_busy),
    .q     (tb_s)
  );

  assign mem_row      = row;
  assign mem_col      = col;
  assign mem_write_en = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      sent           <= SENT_HDR;
      row            <= '0;
      col            <= '0;
      csum           <= '0;
      timer          <= '0;
      armed          <= 1'b0;
      mem_matrix_sel <= '0;
      tx_load        <= 1'b0;
      tx_data        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      done  <= 1'b0;
      // armed stays low for the first edge after reset release so a start
      // pulse coincident with release is not taken.
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (start && armed) begin
            csum           <= '0;
            row            <= '0;
            col            <= '0;
            error          <= 1'b0;
            busy           <= 1'b1;
            mem_matrix_sel <= RESULT_SEL;
            state          <= HDR;
          end
        end
        HDR: begin
          tx_data <= HEADER;
          sent    <= SENT_HDR;
          state   <= LOAD;
        end
        RD_ADDR: state <= RD_WAIT;
        RD_WAIT: begin
          tx_data <= mem_read_data;
          csum    <= csum ^ mem_read_data;
          sent    <= SENT_DATA;
          state   <= LOAD;
        end
        LOAD: begin
          tx_load <= 1'b1;
          timer   <= '0;
          state   <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (tb_s) begin
            tx_load <= 1'b0;
            state   <= WAIT_DONE;
          end else if (timer == TIMER_MAX) begin
            error          <= 1'b1;
            tx_load        <= 1'b0;
            busy           <= 1'b0;
            mem_matrix_sel <= '0;
            state          <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tb_s) begin
            case (sent)
              SENT_HDR: state <= RD_ADDR;
              SENT_DATA: begin
                if (row == LAST && col == LAST) begin
                  state <= CSUM;
                end else begin
                  if (col == LAST) begin
                    col <= '0;
                    row <= row + 1'b1;
                  end else begin
                    col <= col + 1'b1;
                  end
                  state <= RD_ADDR;
                end
              end
              default: state <= FIN;
            endcase
          end
        end
        CSUM: begin
          tx_data <= csum;
          sent    <= SENT_CSUM;
          state   <= LOAD;
        end
        FIN: begin
          done           <= 1'b1;
          busy           <= 1'b0;
          mem_matrix_sel <= '0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Self-checking bench for matrix_result_streamer: memory and Transmitter
// models, a frame reference model built from the matrix contents, a table of
// frame scenarios, and hand-written timeout / mid-frame start / reset cases.
module tb_matrix_result_streamer;

  localparam int N = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] mem_read_data;
  logic       tx_busy;
  logic [1:0] mem_matrix_sel;
  logic [3:0] mem_row, mem_col;
  logic       mem_write_en, tx_load, busy, done, error;
  logic [7:0] tx_data;

  matrix_result_streamer #(.ACK_TIMEOUT(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .mem_read_data  (mem_read_data),
    .tx_busy        (tx_busy),
    .mem_matrix_sel (mem_matrix_sel),
    .mem_row        (mem_row),
    .mem_col        (mem_col),
    .mem_write_en   (mem_write_en),
    .tx_load        (tx_load),
    .tx_data        (tx_data),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // ---------------- memory model ----------------
  logic [7:0] mem [N][N];
  always @(posedge clk) begin
    if (int'(mem_row) < N && int'(mem_col) < N) mem_read_data <= mem[mem_row][mem_col];
    else mem_read_data <= 8'h00;
  end

  // ---------------- Transmitter model ----------------
  // busy rises 3 clk after a load is seen and is held for 20 clk.
  bit        ack_en = 1'b1;
  logic [7:0] rx_q[$];
  int        tm_st, tm_cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_busy <= 1'b0;
      tm_st   <= 0;
      tm_cnt  <= 0;
    end else begin
      case (tm_st)
        0: if (tx_load && ack_en) begin
             rx_q.push_back(tx_data);
             tm_st  <= 1;
             tm_cnt <= 0;
           end
        1: if (tm_cnt == 1) begin
             tx_busy <= 1'b1;
             tm_st   <= 2;
             tm_cnt  <= 0;
           end else tm_cnt <= tm_cnt + 1;
        default: if (tm_cnt == 19) begin
             tx_busy <= 1'b0;
             tm_st   <= 0;
           end else tm_cnt <= tm_cnt + 1;
      endcase
    end
  end

  int done_cnt = 0;
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  // ---------------- invariants ----------------
  int         inv_viol = 0;
  logic       prev_load = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (reset) begin
      if (mem_write_en !== 1'b0) inv_viol <= inv_viol + 1;
      if (int'(mem_row) >= N || int'(mem_col) >= N) inv_viol <= inv_viol + 1;
      if (tx_load && prev_load && tx_data !== prev_data) inv_viol <= inv_viol + 1;
    end
    prev_load <= tx_load;
    prev_data <= tx_data;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fill_mem(input int mode);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        case (mode)
          0:       mem[r][c] = 8'((r << 4) | c);
          1:       mem[r][c] = (r == c) ? 8'h01 : 8'h00;
          default: mem[r][c] = 8'($urandom);
        endcase
  endtask

  // Reference frame: header, all cells row-major, XOR of the cells.
  task automatic build_frame(output logic [7:0] f[$]);
    logic [7:0] x = 8'h00;
    f.delete();
    f.push_back(8'hA5);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        f.push_back(mem[r][c]);
        x ^= mem[r][c];
      end
    f.push_back(x);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_frame_end(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 12000; n++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    repeat (30) @(negedge clk);
  endtask

  task automatic wait_bytes(input int base, input int cnt, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 12000; n++) begin
      @(negedge clk);
      if (rx_q.size() - base >= cnt) begin ok = 1'b1; break; end
    end
  endtask

  // Compare captured bytes from base against the reference; -1 = match.
  task automatic compare_frame(input int base, output int idx);
    logic [7:0] f[$];
    build_frame(f);
    idx = -1;
    for (int i = 0; i < f.size(); i++)
      if (base + i >= rx_q.size() || rx_q[base + i] !== f[i]) begin idx = i; break; end
  endtask

  typedef struct {
    int         mode;
    int         exp_len;
    int         exp_done;
    logic [7:0] exp_first;
    bit         csum_known;
    logic [7:0] exp_csum;
  } vec_t;

  vec_t vecs[4];

  initial begin
    bit ok;
    int base, dbase, idx, n;

    vecs[0] = '{mode: 0, exp_len: 102, exp_done: 1, exp_first: 8'hA5, csum_known: 1'b1, exp_csum: 8'h00};
    vecs[1] = '{mode: 1, exp_len: 102, exp_done: 1, exp_first: 8'hA5, csum_known: 1'b1, exp_csum: 8'h00};
    vecs[2] = '{mode: 2, exp_len: 102, exp_done: 1, exp_first: 8'hA5, csum_known: 1'b0, exp_csum: 8'h00};
    vecs[3] = '{mode: 2, exp_len: 102, exp_done: 1, exp_first: 8'hA5, csum_known: 1'b0, exp_csum: 8'h00};

    fill_mem(0);
    repeat (3) @(negedge clk);
    check("reset_outputs", {22'd0, mem_matrix_sel, mem_row, mem_col, mem_write_en, tx_load,
                            tx_data, busy, done, error}, 32'd0);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);

    // ---- table-driven frames ----
    foreach (vecs[i]) begin
      fill_mem(vecs[i].mode);
      base  = rx_q.size();
      dbase = done_cnt;
      pulse_start();
      check($sformatf("v%0d_busy_sel", i), {busy, mem_matrix_sel}, {1'b1, 2'd2});
      wait_frame_end(ok);
      check($sformatf("v%0d_finished", i), ok, 1);
      check($sformatf("v%0d_len", i), rx_q.size() - base, vecs[i].exp_len);
      check($sformatf("v%0d_done", i), done_cnt - dbase, vecs[i].exp_done);
      check($sformatf("v%0d_first", i), rx_q[base], vecs[i].exp_first);
      compare_frame(base, idx);
      check($sformatf("v%0d_content_mismatch_idx", i), idx, 32'hFFFF_FFFF);
      if (vecs[i].csum_known)
        check($sformatf("v%0d_csum", i), rx_q[base + 101], vecs[i].exp_csum);
      if (vecs[i].mode == 0) begin
        check("pattern_row_wrap", rx_q[base + 11], 8'h10);
        check("pattern_last_cell", rx_q[base + 100], 8'h99);
      end
      check($sformatf("v%0d_idle_sel", i), {busy, mem_matrix_sel}, 3'b000);
    end

    // ---- ack timeout ----
    ack_en = 1'b0;
    dbase  = done_cnt;
    pulse_start();
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (tx_load) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("timeout_load_seen", ok, 1);
    n = 0;
    for (int k = 0; k < 100 && !error; k++) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, 16);
    check("timeout_error_busy_load", {error, busy, tx_load}, 3'b100);
    repeat (10) @(negedge clk);
    check("timeout_no_done", done_cnt - dbase, 0);
    check("timeout_error_sticky", error, 1);
    ack_en = 1'b1;
    fill_mem(2);
    base = rx_q.size();
    pulse_start();
    check("start_clears_error", error, 0);
    wait_frame_end(ok);
    check("after_timeout_len", rx_q.size() - base, 102);
    compare_frame(base, idx);
    check("after_timeout_content", idx, 32'hFFFF_FFFF);

    // ---- start mid-frame ignored ----
    fill_mem(0);
    base  = rx_q.size();
    dbase = done_cnt;
    pulse_start();
    wait_bytes(base, 40, ok);
    check("mid_reach_40", ok, 1);
    pulse_start();
    wait_frame_end(ok);
    check("mid_len", rx_q.size() - base, 102);
    check("mid_done", done_cnt - dbase, 1);
    compare_frame(base, idx);
    check("mid_content", idx, 32'hFFFF_FFFF);

    // ---- reset mid-frame ----
    fill_mem(2);
    base  = rx_q.size();
    dbase = done_cnt;
    pulse_start();
    wait_bytes(base, 57, ok);
    check("rst_reach_57", ok, 1);
    reset = 1'b0;
    #1;
    check("rst_outputs_zero", {22'd0, mem_matrix_sel, mem_row, mem_col, mem_write_en, tx_load,
                               tx_data, busy, done, error}, 32'd0);
    repeat (5) @(negedge clk);
    // start coincident with reset release must be ignored
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_release_start_ignored", busy, 0);
    repeat (30) @(negedge clk);
    check("rst_no_done", done_cnt - dbase, 0);
    base  = rx_q.size();
    dbase = done_cnt;
    pulse_start();
    wait_frame_end(ok);
    check("fresh_len", rx_q.size() - base, 102);
    check("fresh_first", rx_q[base], 8'hA5);
    check("fresh_done", done_cnt - dbase, 1);
    compare_frame(base, idx);
    check("fresh_content", idx, 32'hFFFF_FFFF);

    check("invariant_violations", inv_viol, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
